// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Generates the instruction-fetch address. After reset the PC spends one
// BOOT cycle at RESET_VEC and then advances by STEP each cycle. Branch/jump
// redirects and traps replace the sequential PC. A redirect or trap that
// arrives while the pipeline is stalled is held in a one-entry buffer and
// applied on the first unstalled edge.
//
// Build option: define PC_ALIGN_CHK_EN to check redirect-target alignment.
// A target with any low log2(STEP) bit set is then replaced by TRAP_VEC and
// handled as a trap, and misalign pulses for one cycle. Without the macro,
// targets are used as given and misalign stays 0.
//
// Ports:
//   clk_pc        in   clock, rising edge
//   rst_pc        in   asynchronous active-high reset
//   stall         in   pipeline stall, PC holds
//   redir_valid   in   redirect request (one-cycle pulse)
//   redir_target  in   redirect target address
//   trap_valid    in   trap request (one-cycle pulse), target TRAP_VEC
//   pc            out  current fetch address (registered)
//   pc_seq        out  pc + STEP, wraps modulo 2^ADDR_W
//   pc_valid      out  pc holds a fetchable address
//   redir_pending out  a redirect/trap is buffered during a stall
//   misalign      out  misaligned redirect target substituted (pulse)
module pc_gen #(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_VEC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0]   TRAP_VEC  = ADDR_W'(32'h0000_0100),
  parameter int unsigned         STEP      = 4
) (
  input  logic              clk_pc,
  input  logic              rst_pc,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              trap_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              pc_valid,
  output logic              redir_pending,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_buf;
  logic              r_buf_trap;
  logic              r_pc_valid;
  logic              r_pending;
  logic              r_misalign;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_buf_nxt;
  logic              w_buf_trap_nxt;
  logic              w_mis_nxt;
  logic              w_mis;
  logic              w_eff_trap;
  logic              w_eff_redir;

`ifdef PC_ALIGN_CHK_EN
  // With STEP=1 the mask is zero, so no target is ever flagged.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  assign w_mis = redir_valid && ((redir_target & ALIGN_MASK) != {ADDR_W{1'b0}});
`else
  assign w_mis = 1'b0;
`endif

  // A misaligned redirect behaves exactly like a trap from here on.
  assign w_eff_trap  = trap_valid | w_mis;
  assign w_eff_redir = redir_valid & ~w_mis;

  // Next-state, next-PC and pending-buffer selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_nxt      = r_buf;
    w_buf_trap_nxt = r_buf_trap;
    w_mis_nxt      = 1'b0;
    case (r_state)
      S_BOOT: begin
        // Inputs are ignored for the single boot cycle.
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Substitution only matters if a real trap is not already winning.
        w_mis_nxt = w_mis & ~trap_valid;
        if (w_eff_trap && !stall) begin
          w_pc_nxt = TRAP_VEC;
        end else if (w_eff_redir && !stall) begin
          w_pc_nxt = redir_target;
        end else if (w_eff_trap || w_eff_redir) begin
          w_buf_nxt      = w_eff_trap ? TRAP_VEC : redir_target;
          w_buf_trap_nxt = w_eff_trap;
          w_state_nxt    = S_PEND;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else begin
          w_pc_nxt = r_pc + STEP_V;
        end
      end
      S_PEND: begin
        w_mis_nxt = w_mis & ~trap_valid;
        if (stall) begin
          // Trap always overwrites; a redirect never displaces a trap.
          if (w_eff_trap) begin
            w_buf_nxt      = TRAP_VEC;
            w_buf_trap_nxt = 1'b1;
          end else if (w_eff_redir && !r_buf_trap) begin
            w_buf_nxt = redir_target;
          end else begin
            w_buf_nxt = r_buf;
          end
        end else begin
          // Release: same-cycle arrivals follow the same overwrite rules.
          w_state_nxt    = S_RUN;
          w_buf_nxt      = {ADDR_W{1'b0}};
          w_buf_trap_nxt = 1'b0;
          if (w_eff_trap) begin
            w_pc_nxt = TRAP_VEC;
          end else if (w_eff_redir && !r_buf_trap) begin
            w_pc_nxt = redir_target;
          end else begin
            w_pc_nxt = r_buf;
          end
        end
      end
      default: begin
        // Unreachable encoding: recover through BOOT at the reset vector.
        w_state_nxt    = S_BOOT;
        w_pc_nxt       = RESET_VEC;
        w_buf_nxt      = {ADDR_W{1'b0}};
        w_buf_trap_nxt = 1'b0;
      end
    endcase
  end

  // State, PC, buffer and registered status outputs.
  always_ff @(posedge clk_pc or posedge rst_pc) begin
    if (rst_pc) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VEC;
      r_buf      <= {ADDR_W{1'b0}};
      r_buf_trap <= 1'b0;
      r_pc_valid <= 1'b0;
      r_pending  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_trap <= w_buf_trap_nxt;
      r_pc_valid <= 1'b1;
      r_pending  <= (w_state_nxt == S_PEND);
      r_misalign <= w_mis_nxt;
    end
  end

  assign pc            = r_pc;
  assign pc_seq        = r_pc + STEP_V;
  assign pc_valid      = r_pc_valid;
  assign redir_pending = r_pending;
  assign misalign      = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (32-bit default
// instance plus an 8-bit instance for narrow wrap-around).
module tb_pc_gen;

  logic        clk_pc = 1'b0;
  logic        rst_pc;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        trap_valid;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        pc_valid;
  logic        redir_pending;
  logic        misalign;

  logic        rst8;
  logic        redir_valid8;
  logic [7:0]  redir_target8;
  logic [7:0]  pc8;
  logic [7:0]  pc_seq8;
  logic        pc_valid8;
  logic        redir_pending8;
  logic        misalign8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_pc = ~clk_pc;

  pc_gen u_dut (
    .clk_pc(clk_pc), .rst_pc(rst_pc), .stall(stall),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .trap_valid(trap_valid), .pc(pc), .pc_seq(pc_seq),
    .pc_valid(pc_valid), .redir_pending(redir_pending), .misalign(misalign)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .STEP(4)) u_dut8 (
    .clk_pc(clk_pc), .rst_pc(rst8), .stall(1'b0),
    .redir_valid(redir_valid8), .redir_target(redir_target8),
    .trap_valid(1'b0), .pc(pc8), .pc_seq(pc_seq8),
    .pc_valid(pc_valid8), .redir_pending(redir_pending8), .misalign(misalign8)
  );

  task automatic tick();
    @(posedge clk_pc);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
    n_vec++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", pc_valid); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL reset_pend got=%b want=0", redir_pending); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_mis got=%b want=0", misalign); end
    rst_pc = 1'b0;
    tick();  // BOOT edge
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL boot_pc got=%h want=%h", pc, 32'h0); end
    n_vec++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL boot_valid got=%b want=1", pc_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (pc !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, pc, 32'(4 * i)); end
      n_vec++; if (pc_seq !== 32'(4 * i + 4)) begin n_err++; $display("FAIL seq_pcseq[%0d] got=%h want=%h", i, pc_seq, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_redirect();
    repeat (5) tick();
    n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL pre_redir_pc got=%h want=%h", pc, 32'h20); end
    redir_valid = 1'b1; redir_target = 32'h80;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc !== 32'h80) begin n_err++; $display("FAIL redir_pc got=%h want=%h", pc, 32'h80); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL redir_pend got=%b want=0", redir_pending); end
    tick();
    n_vec++; if (pc !== 32'h84) begin n_err++; $display("FAIL redir_next got=%h want=%h", pc, 32'h84); end
  endtask

  task automatic test_stall_redir();
    redir_valid = 1'b1; redir_target = 32'h40;
    tick();
    redir_valid = 1'b0;
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h90;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL stall_hold got=%h want=%h", pc, 32'h40); end
    n_vec++; if (redir_pending !== 1'b1) begin n_err++; $display("FAIL stall_pend got=%b want=1", redir_pending); end
    tick();
    redir_valid = 1'b1; redir_target = 32'hA0;
    tick();
    redir_valid = 1'b0;
    repeat (2) tick();
    n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL stall_hold2 got=%h want=%h", pc, 32'h40); end
    n_vec++; if (redir_pending !== 1'b1) begin n_err++; $display("FAIL stall_pend2 got=%b want=1", redir_pending); end
    stall = 1'b0;
    tick();
    n_vec++; if (pc !== 32'hA0) begin n_err++; $display("FAIL release_pc got=%h want=%h", pc, 32'hA0); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL release_pend got=%b want=0", redir_pending); end
    tick();
    n_vec++; if (pc !== 32'hA4) begin n_err++; $display("FAIL release_next got=%h want=%h", pc, 32'hA4); end
  endtask

  task automatic test_trap_buffer();
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h90;
    tick();
    redir_valid = 1'b0; trap_valid = 1'b1;
    tick();
    trap_valid = 1'b0; redir_valid = 1'b1; redir_target = 32'hB0;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc !== 32'hA4) begin n_err++; $display("FAIL trapbuf_hold got=%h want=%h", pc, 32'hA4); end
    stall = 1'b0;
    tick();
    n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL trapbuf_pc got=%h want=%h", pc, 32'h100); end
    tick();
    n_vec++; if (pc !== 32'h104) begin n_err++; $display("FAIL trapbuf_next got=%h want=%h", pc, 32'h104); end
  endtask

  task automatic test_priority();
    // Simultaneous unstalled trap and redirect: trap wins.
    trap_valid = 1'b1; redir_valid = 1'b1; redir_target = 32'h300;
    tick();
    trap_valid = 1'b0; redir_valid = 1'b0;
    n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL prio_pc got=%h want=%h", pc, 32'h100); end
    // Buffered redirect overridden by a redirect arriving on release.
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h90;
    tick();
    stall = 1'b0; redir_target = 32'hC0;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc !== 32'hC0) begin n_err++; $display("FAIL relover_pc got=%h want=%h", pc, 32'hC0); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL relover_pend got=%b want=0", redir_pending); end
  endtask

  task automatic test_wrap();
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc_seq !== 32'h0) begin n_err++; $display("FAIL wrap_pcseq got=%h want=%h", pc_seq, 32'h0); end
    tick();
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h want=%h", pc, 32'h0); end
    rst8 = 1'b0;
    tick();  // BOOT edge of the narrow instance
    redir_valid8 = 1'b1; redir_target8 = 8'hFC;
    tick();
    redir_valid8 = 1'b0;
    n_vec++; if (pc8 !== 8'hFC) begin n_err++; $display("FAIL wrap8_pre got=%h want=%h", pc8, 8'hFC); end
    n_vec++; if (pc_seq8 !== 8'h00) begin n_err++; $display("FAIL wrap8_pcseq got=%h want=%h", pc_seq8, 8'h00); end
    tick();
    n_vec++; if (pc8 !== 8'h00) begin n_err++; $display("FAIL wrap8_pc got=%h want=%h", pc8, 8'h00); end
  endtask

  task automatic test_reset_mid_pend();
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h90;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (redir_pending !== 1'b1) begin n_err++; $display("FAIL midrst_prepend got=%b want=1", redir_pending); end
    #2 rst_pc = 1'b1;
    #1;
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL midrst_pc got=%h want=%h", pc, 32'h0); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL midrst_pend got=%b want=0", redir_pending); end
    n_vec++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b want=0", pc_valid); end
    tick();
    rst_pc = 1'b0; trap_valid = 1'b1;  // stall and trap must be ignored in BOOT
    tick();
    trap_valid = 1'b0;
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reboot_pc got=%h want=%h", pc, 32'h0); end
    n_vec++; if (redir_pending !== 1'b0) begin n_err++; $display("FAIL reboot_pend got=%b want=0", redir_pending); end
    n_vec++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL reboot_valid got=%b want=1", pc_valid); end
    stall = 1'b0;
    tick();
    n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL reboot_next got=%h want=%h", pc, 32'h4); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef PC_ALIGN_CHK_EN
    exp_pc = 32'h100; exp_mis = 1'b1;
`else
    exp_pc = 32'h82;  exp_mis = 1'b0;
`endif
    redir_valid = 1'b1; redir_target = 32'h82;
    tick();
    redir_valid = 1'b0;
    n_vec++; if (pc !== exp_pc) begin n_err++; $display("FAIL mis_pc got=%h want=%h", pc, exp_pc); end
    n_vec++; if (misalign !== exp_mis) begin n_err++; $display("FAIL mis_pulse got=%b want=%b", misalign, exp_mis); end
    tick();
    n_vec++; if (pc !== exp_pc + 32'h4) begin n_err++; $display("FAIL mis_next got=%h want=%h", pc, exp_pc + 32'h4); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear got=%b want=0", misalign); end
  endtask

  initial begin
    rst_pc = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0; trap_valid = 1'b0;
    rst8 = 1'b1; redir_valid8 = 1'b0; redir_target8 = 8'h00;
    test_reset();
    test_redirect();
    test_stall_redir();
    test_trap_buffer();
    test_priority();
    test_wrap();
    test_reset_mid_pend();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
